// File: rtl/overlap_arb_pkg.sv
// Shared types and constants for the overlapping-window bus arbiter.
// The low requester owns bus16[11:0] and the high requester owns bus16[15:4].
package overlap_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_LO = 2'd1,
        GNT_HI = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LO   = 2'd1,
        SRC_HI   = 2'd2
    } src_t;

    localparam logic [15:0] LO_MASK = 16'h0FFF;
    localparam logic [15:0] HI_MASK = 16'hFFF0;

endpackage

// File: rtl/overlap_bus_arbiter_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Once it reaches all-ones it holds until the next reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/overlap_bus_arbiter.sv
// Round-robin arbiter for two requesters writing overlapping windows of bus16,
// with bounded locked bursts and a count of cross-requester overlap overwrites.
module overlap_bus_arbiter
    import overlap_arb_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000,
    parameter int          MAX_BURST = 4,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lo_valid,
    input  logic             lo_lock,
    input  logic [11:0]      lo_data,
    output logic             lo_ready,
    input  logic             hi_valid,
    input  logic             hi_lock,
    input  logic [11:0]      hi_data,
    output logic             hi_ready,
    output logic [15:0]      bus16,
    output logic [11:0]      low12,
    output logic [11:0]      high12,
    output logic             upd,
    output logic [1:0]       upd_src,
    output logic [CNT_W-1:0] clobber_cnt
);

    localparam logic [4:0] MAX_B = 5'(MAX_BURST);

    state_t      state_reg, state_next;
    src_t        ptr_reg, ptr_next;
    src_t        owner_reg, owner_next;
    src_t        upd_src_reg, upd_src_next;
    logic [3:0]  beat_cnt_reg, beat_cnt_next;
    logic [15:0] bus16_reg, bus16_next;
    logic        upd_reg, upd_next;
    logic        clobber_inc;
    logic        burst_more;

    assign lo_ready = (state_reg == GNT_LO);
    assign hi_ready = (state_reg == GNT_HI);

    // True when the beat being accepted now is not the last one the burst may take.
    assign burst_more = (({1'b0, beat_cnt_reg} + 5'd1) < MAX_B);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        upd_src_next  = upd_src_reg;
        beat_cnt_next = beat_cnt_reg;
        bus16_next    = bus16_reg;
        upd_next      = 1'b0;
        clobber_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lo_valid && (!hi_valid || ptr_reg == SRC_LO)) begin
                    state_next = GNT_LO;
                end else if (hi_valid) begin
                    state_next = GNT_HI;
                end
            end
            GNT_LO: begin
                if (lo_valid) begin
                    bus16_next   = (bus16_reg & ~LO_MASK) | ({4'h0, lo_data} & LO_MASK);
                    upd_next     = 1'b1;
                    upd_src_next = SRC_LO;
                    owner_next   = SRC_LO;
                    clobber_inc  = (owner_reg != SRC_NONE) && (owner_reg != SRC_LO);
                    if (lo_lock && burst_more) begin
                        beat_cnt_next = beat_cnt_reg + 4'd1;
                    end else begin
                        beat_cnt_next = 4'd0;
                        ptr_next      = SRC_HI;
                        state_next    = hi_valid ? GNT_HI : IDLE;
                    end
                end else begin
                    beat_cnt_next = 4'd0;
                    state_next    = hi_valid ? GNT_HI : IDLE;
                end
            end
            GNT_HI: begin
                if (hi_valid) begin
                    bus16_next   = (bus16_reg & ~HI_MASK) | ({hi_data, 4'h0} & HI_MASK);
                    upd_next     = 1'b1;
                    upd_src_next = SRC_HI;
                    owner_next   = SRC_HI;
                    clobber_inc  = (owner_reg != SRC_NONE) && (owner_reg != SRC_HI);
                    if (hi_lock && burst_more) begin
                        beat_cnt_next = beat_cnt_reg + 4'd1;
                    end else begin
                        beat_cnt_next = 4'd0;
                        ptr_next      = SRC_LO;
                        state_next    = lo_valid ? GNT_LO : IDLE;
                    end
                end else begin
                    beat_cnt_next = 4'd0;
                    state_next    = lo_valid ? GNT_LO : IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= SRC_LO;
            owner_reg    <= SRC_NONE;
            upd_src_reg  <= SRC_NONE;
            beat_cnt_reg <= 4'd0;
            bus16_reg    <= RESET_VAL;
            upd_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            upd_src_reg  <= upd_src_next;
            beat_cnt_reg <= beat_cnt_next;
            bus16_reg    <= bus16_next;
            upd_reg      <= upd_next;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_clobber (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (clobber_inc),
        .cnt  (clobber_cnt)
    );

    assign bus16   = bus16_reg;
    assign low12   = bus16_reg[11:0];
    assign high12  = bus16_reg[15:4];
    assign upd     = upd_reg;
    assign upd_src = upd_src_reg;

endmodule

// File: tb/tb_overlap_bus_arbiter.sv
// Directed bench for overlap_bus_arbiter; a second instance with a 2-bit
// clobber counter shares the stimulus to exercise saturation.
module tb_overlap_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        lo_valid, lo_lock, hi_valid, hi_lock;
    logic [11:0] lo_data, hi_data;

    logic        lo_ready, hi_ready, upd;
    logic [15:0] bus16;
    logic [11:0] low12, high12;
    logic [1:0]  upd_src;
    logic [7:0]  clobber_cnt;

    logic        lo_ready_s, hi_ready_s, upd_s;
    logic [15:0] bus16_s;
    logic [11:0] low12_s, high12_s;
    logic [1:0]  upd_src_s;
    logic [1:0]  clobber_cnt_s;

    int n_vec = 0;
    int n_err = 0;

    overlap_bus_arbiter #(.RESET_VAL(16'h0000), .MAX_BURST(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lo_valid(lo_valid), .lo_lock(lo_lock), .lo_data(lo_data), .lo_ready(lo_ready),
        .hi_valid(hi_valid), .hi_lock(hi_lock), .hi_data(hi_data), .hi_ready(hi_ready),
        .bus16(bus16), .low12(low12), .high12(high12),
        .upd(upd), .upd_src(upd_src), .clobber_cnt(clobber_cnt)
    );

    overlap_bus_arbiter #(.RESET_VAL(16'h0000), .MAX_BURST(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .lo_valid(lo_valid), .lo_lock(lo_lock), .lo_data(lo_data), .lo_ready(lo_ready_s),
        .hi_valid(hi_valid), .hi_lock(hi_lock), .hi_data(hi_data), .hi_ready(hi_ready_s),
        .bus16(bus16_s), .low12(low12_s), .high12(high12_s),
        .upd(upd_s), .upd_src(upd_src_s), .clobber_cnt(clobber_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic log_txn();
        $display("txn t=%0t upd=%0b src=%0d bus16=%h clobber=%0d clobber_small=%0d",
                 $time, upd, upd_src, bus16, clobber_cnt, clobber_cnt_s);
    endtask

    // Both-valid alternation expectations (one entry per edge after the first grant)
    logic [15:0] t3_bus   [4] = '{16'h1111, 16'h3331, 16'h3222, 16'h4442};
    logic [1:0]  t3_src   [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    logic [7:0]  t3_clob  [4] = '{8'd2, 8'd3, 8'd4, 8'd5};
    logic [1:0]  t3_clobs [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    logic        t3_lrdy  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        t3_hrdy  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Locked LO burst capped at 4 beats with HI waiting
    logic [15:0] t4_bus   [7] = '{16'h4001, 16'h4002, 16'h4003, 16'h4004, 16'h5554, 16'h5005, 16'h5006};
    logic [1:0]  t4_src   [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    logic [7:0]  t4_clob  [7] = '{8'd6, 8'd6, 8'd6, 8'd6, 8'd7, 8'd8, 8'd8};
    logic        t4_lrdy  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t4_hrdy  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n    = 1'b0;
        lo_valid = 1'b0; lo_lock = 1'b0; lo_data = 12'h000;
        hi_valid = 1'b0; hi_lock = 1'b0; hi_data = 12'h000;
        step();
        step();
        check_eq("rst_bus16", 32'(bus16), 32'h0000);
        check_eq("rst_lo_ready", 32'(lo_ready), 32'd0);
        check_eq("rst_hi_ready", 32'(hi_ready), 32'd0);
        check_eq("rst_upd", 32'(upd), 32'd0);
        check_eq("rst_upd_src", 32'(upd_src), 32'd0);
        check_eq("rst_clobber", 32'(clobber_cnt), 32'd0);
        rst_n = 1'b1;

        // Single LO beat
        lo_valid = 1'b1; lo_data = 12'hABC;
        check_eq("t1_idle_lo_ready", 32'(lo_ready), 32'd0);
        step();
        check_eq("t1_lo_ready", 32'(lo_ready), 32'd1);
        check_eq("t1_upd_pre", 32'(upd), 32'd0);
        step();
        log_txn();
        lo_valid = 1'b0;
        check_eq("t1_bus16", 32'(bus16), 32'h0ABC);
        check_eq("t1_upd", 32'(upd), 32'd1);
        check_eq("t1_upd_src", 32'(upd_src), 32'd1);
        check_eq("t1_clobber", 32'(clobber_cnt), 32'd0);
        check_eq("t1_lo_ready_rel", 32'(lo_ready), 32'd0);
        step();
        check_eq("t1_upd_pulse", 32'(upd), 32'd0);

        // Single HI beat clobbers the overlap
        hi_valid = 1'b1; hi_data = 12'h123;
        step();
        check_eq("t2_hi_ready", 32'(hi_ready), 32'd1);
        step();
        log_txn();
        hi_valid = 1'b0;
        check_eq("t2_bus16", 32'(bus16), 32'h123C);
        check_eq("t2_high12", 32'(high12), 32'h123);
        check_eq("t2_low12", 32'(low12), 32'h23C);
        check_eq("t2_upd_src", 32'(upd_src), 32'd2);
        check_eq("t2_clobber", 32'(clobber_cnt), 32'd1);

        // Both valid, no lock: strict alternation with no IDLE gaps
        lo_valid = 1'b1; lo_data = 12'h111;
        hi_valid = 1'b1; hi_data = 12'h333;
        step();
        check_eq("t3_first_lo", 32'(lo_ready), 32'd1);
        check_eq("t3_first_hi", 32'(hi_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            log_txn();
            check_eq("t3_bus16", 32'(bus16), 32'(t3_bus[k]));
            check_eq("t3_upd", 32'(upd), 32'd1);
            check_eq("t3_upd_src", 32'(upd_src), 32'(t3_src[k]));
            check_eq("t3_clobber", 32'(clobber_cnt), 32'(t3_clob[k]));
            check_eq("t3_clobber_sat", 32'(clobber_cnt_s), 32'(t3_clobs[k]));
            check_eq("t3_lo_ready", 32'(lo_ready), 32'(t3_lrdy[k]));
            check_eq("t3_hi_ready", 32'(hi_ready), 32'(t3_hrdy[k]));
            case (k)
                0: lo_data = 12'h222;
                1: hi_data = 12'h444;
                2: lo_valid = 1'b0;
                default: hi_valid = 1'b0;
            endcase
        end

        // Locked LO burst of 6 beats, HI waiting
        lo_valid = 1'b1; lo_lock = 1'b1; lo_data = 12'h001;
        hi_valid = 1'b1; hi_lock = 1'b0; hi_data = 12'h555;
        step();
        check_eq("t4_first_lo", 32'(lo_ready), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step();
            log_txn();
            check_eq("t4_bus16", 32'(bus16), 32'(t4_bus[k]));
            check_eq("t4_upd_src", 32'(upd_src), 32'(t4_src[k]));
            check_eq("t4_clobber", 32'(clobber_cnt), 32'(t4_clob[k]));
            check_eq("t4_clobber_sat", 32'(clobber_cnt_s), 32'd3);
            check_eq("t4_lo_ready", 32'(lo_ready), 32'(t4_lrdy[k]));
            check_eq("t4_hi_ready", 32'(hi_ready), 32'(t4_hrdy[k]));
            if (k == 4) hi_valid = 1'b0;
            else lo_data = lo_data + 12'h001;
            if (k == 5) lo_lock = 1'b0;
            if (k == 6) lo_valid = 1'b0;
        end

        // Reset in the middle of a locked HI burst
        hi_valid = 1'b1; hi_lock = 1'b1; hi_data = 12'hABC;
        step();
        check_eq("t5_hi_ready", 32'(hi_ready), 32'd1);
        step();
        log_txn();
        check_eq("t5_bus16_pre", 32'(bus16), 32'hABC6);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_bus16", 32'(bus16), 32'h0000);
        check_eq("t5_rst_hi_ready", 32'(hi_ready), 32'd0);
        check_eq("t5_rst_lo_ready", 32'(lo_ready), 32'd0);
        check_eq("t5_rst_upd", 32'(upd), 32'd0);
        check_eq("t5_rst_clobber", 32'(clobber_cnt), 32'd0);
        check_eq("t5_rst_clobber_sat", 32'(clobber_cnt_s), 32'd0);
        hi_valid = 1'b0; hi_lock = 1'b0;
        step();
        check_eq("t5_hold_bus16", 32'(bus16), 32'h0000);
        rst_n = 1'b1;
        lo_valid = 1'b1; lo_data = 12'h777;
        step();
        check_eq("t5_lo_ready", 32'(lo_ready), 32'd1);
        step();
        log_txn();
        lo_valid = 1'b0;
        check_eq("t5_bus16", 32'(bus16), 32'h0777);
        check_eq("t5_upd_src", 32'(upd_src), 32'd1);
        check_eq("t5_clobber", 32'(clobber_cnt), 32'd0);
        check_eq("t5_clobber_sat", 32'(clobber_cnt_s), 32'd0);
        step();
        check_eq("t5_upd_pulse", 32'(upd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
